audio_attr_reader: RTL and testbench
====================================

AUDIO_ATTR_READER -- requirements
Module: audio_attr_reader

Interface
REQ-001 Parameter NUM_VOICES, default 32, number of voices scanned per frame, legal range 1..32.
REQ-002 clk_i  input  1  sole clock; the attribute RAM read port is clocked by the same clock.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 sample_strobe_i  input  1  one-cycle pulse that starts a scan frame.
REQ-005 ram_rd_en_o  output  1  attribute RAM read enable.
REQ-006 ram_rd_addr_o  output  5  attribute RAM word address; equals the voice index.
REQ-007 ram_rd_data_i  input  32  attribute RAM word; valid one clock after its address is presented.
REQ-008 voice_valid_o  output  1  decoded voice record is valid.
REQ-009 voice_ready_i  input  1  downstream accepts the record.
REQ-010 voice_idx_o  output  5  voice index of the record.
REQ-011 freq_o  output  16  phase increment, word bits [15:0].
REQ-012 vol_o  output  6  volume, word bits [21:16].
REQ-013 left_en_o / right_en_o  output  1 each  word bits [22] and [23].
REQ-014 pw_o  output  6  pulse width, word bits [29:24].
REQ-015 wave_o  output  2  waveform, word bits [31:30].
REQ-016 busy_o  output  1  a scan is in progress.
REQ-017 done_o  output  1  one-cycle pulse at end of scan.
REQ-018 overrun_o  output  1  sticky; set when a strobe arrives while busy.
REQ-019 overrun_clr_i  input  1  clears overrun_o.

Function
REQ-020 FSM states: IDLE, FETCH, WAIT, OUT, DONE.
REQ-021 IDLE -> FETCH on sample_strobe_i; the voice counter loads 0.
REQ-022 FETCH: ram_rd_en_o=1 and ram_rd_addr_o=counter for one cycle, then -> WAIT.
REQ-023 WAIT: ram_rd_data_i is decoded into the output registers at the end of the cycle, then -> OUT.
REQ-024 OUT: voice_valid_o=1 and every record output is held stable until voice_ready_i=1 is sampled.
REQ-025 On that handshake: if counter=NUM_VOICES-1, -> DONE; otherwise the counter increments and -> FETCH.
REQ-026 DONE: done_o=1 for one cycle, then -> IDLE.
REQ-027 With voice_ready_i held at 1, the first voice_valid_o rises 3 edges after the strobe edge; each voice takes 3 cycles; done_o rises 3*NUM_VOICES+1 edges after the strobe edge.
REQ-028 busy_o=1 in every state except IDLE.
REQ-029 A strobe while busy_o=1 is ignored and sets overrun_o.
REQ-030 If a strobe and overrun_clr_i occur in the same cycle while busy, set wins.
REQ-031 ram_rd_en_o=0 in every state except FETCH; ram_rd_addr_o holds its last value.
REQ-032 voice_valid_o is never asserted outside the OUT state.

Reset
REQ-033 rst_i immediately forces IDLE, counter=0, and every output to 0, including overrun_o and ram_rd_addr_o.
REQ-034 Reset asserted mid-scan aborts the scan with no done_o; the next strobe after release starts from voice 0.

Configuration
REQ-035 Macro AUDIO_ATTR_SKIP_MUTED_EN.
- Defined: a voice with decoded vol=0 bypasses OUT. WAIT goes directly to FETCH for the next voice, or to DONE if it is the last voice. No voice_valid_o is produced for that voice.
- Undefined: every voice 0..NUM_VOICES-1 is emitted regardless of volume.
REQ-036 With AUDIO_ATTR_SKIP_MUTED_EN defined and all voices muted, done_o still pulses, at 2*NUM_VOICES+1 edges after the strobe edge.

Verification
REQ-037 RAM word 0 = 0xC5D2_1234, ready=1, one strobe -> voice 0 record: freq=0x1234, vol=0x12, left=1, right=1, pw=0x05, wave=3; valid rises 3 edges after the strobe.
REQ-038 NUM_VOICES=32, ready=1 -> 32 valids with idx 0..31 in order; done_o rises at edge 97; busy_o=0 afterwards.
REQ-039 Ready held low 10 cycles during voice 5 -> valid and outputs stable for those 10 cycles; no address beyond 5 is issued; voice 6 fetch follows the handshake.
REQ-040 Strobe at cycle 20 of a scan -> scan unaffected, overrun_o=1; then overrun_clr_i pulse -> overrun_o=0.
REQ-041 rst_i asserted during voice 12 OUT -> all outputs 0 asynchronously; after release a new strobe produces voice 0 first.
REQ-042 With AUDIO_ATTR_SKIP_MUTED_EN defined and only voices 3 and 30 non-zero volume -> exactly two valids (idx 3 and 30), then done_o.

Source files
------------

// File: rtl/audio_attr_reader.sv
// audio_attr_reader: scans NUM_VOICES attribute words out of a synchronous
// RAM once per sample frame and presents each one as a decoded voice record
// behind a valid/ready handshake.
// Optional feature macro: AUDIO_ATTR_SKIP_MUTED_EN. When it is defined, voices
// with zero volume are skipped without producing a record.
// Every output is driven directly by a flop. Each output flop is loaded with
// the value that matches the state being entered, so it lines up with state_q.
module audio_attr_reader #(
  parameter int NUM_VOICES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sample_strobe_i,
  output logic        ram_rd_en_o,
  output logic [4:0]  ram_rd_addr_o,
  input  logic [31:0] ram_rd_data_i,
  output logic        voice_valid_o,
  input  logic        voice_ready_i,
  output logic [4:0]  voice_idx_o,
  output logic [15:0] freq_o,
  output logic [5:0]  vol_o,
  output logic        left_en_o,
  output logic        right_en_o,
  output logic [5:0]  pw_o,
  output logic [1:0]  wave_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o,
  input  logic        overrun_clr_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_VOICES - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rd_en_q, rd_en_d;
  logic [4:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;

  // Next-state, voice counter and record capture for the scan sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (sample_strobe_i) begin
          cnt_d   = 5'd0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // RAM data for cnt_q is valid in this cycle; capture it as the record.
        word_d = ram_rd_data_i;
        idx_d  = cnt_q;
`ifdef AUDIO_ATTR_SKIP_MUTED_EN
        if (ram_rd_data_i[21:16] == 6'd0) begin
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_OUT;
        end
`else
        state_d = S_OUT;
`endif
      end
      S_OUT: begin
        if (voice_ready_i) begin
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered output values derived from the state being entered.
  always_comb begin
    rd_en_d = (state_d == S_FETCH);
    valid_d = (state_d == S_OUT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    if (state_d == S_FETCH) begin
      addr_d = cnt_d;
    end else begin
      addr_d = addr_q;
    end
  end

  // Sticky overrun flag; a strobe while busy beats a simultaneous clear.
  always_comb begin
    if (sample_strobe_i && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers with asynchronous reset to all zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      rd_en_q   <= 1'b0;
      addr_q    <= 5'd0;
      valid_q   <= 1'b0;
      idx_q     <= 5'd0;
      word_q    <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign ram_rd_en_o   = rd_en_q;
  assign ram_rd_addr_o = addr_q;
  assign voice_valid_o = valid_q;
  assign voice_idx_o   = idx_q;
  assign freq_o        = word_q[15:0];
  assign vol_o         = word_q[21:16];
  assign left_en_o     = word_q[22];
  assign right_en_o    = word_q[23];
  assign pw_o          = word_q[29:24];
  assign wave_o        = word_q[31:30];
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_audio_attr_reader.sv
// Directed self-checking bench for audio_attr_reader (NUM_VOICES = 32).
// Also exercises voice skipping when AUDIO_ATTR_SKIP_MUTED_EN is defined.
module tb_audio_attr_reader;

  logic        clk;
  logic        rst;
  logic        strobe;
  logic        ram_rd_en;
  logic [4:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic        voice_valid;
  logic        voice_ready;
  logic [4:0]  voice_idx;
  logic [15:0] freq;
  logic [5:0]  vol;
  logic        left_en;
  logic        right_en;
  logic [5:0]  pw;
  logic [1:0]  wave;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        overrun_clr;

  logic [31:0] mem [0:31];

  int checks;
  int failures;

  audio_attr_reader #(.NUM_VOICES(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sample_strobe_i (strobe),
    .ram_rd_en_o     (ram_rd_en),
    .ram_rd_addr_o   (ram_rd_addr),
    .ram_rd_data_i   (ram_rd_data),
    .voice_valid_o   (voice_valid),
    .voice_ready_i   (voice_ready),
    .voice_idx_o     (voice_idx),
    .freq_o          (freq),
    .vol_o           (vol),
    .left_en_o       (left_en),
    .right_en_o      (right_en),
    .pw_o            (pw),
    .wave_o          (wave),
    .busy_o          (busy),
    .done_o          (done),
    .overrun_o       (overrun),
    .overrun_clr_i   (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read attribute RAM: data appears one clock after the address.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0) return 32'hC5D2_1234;
    return {b[1:0], b[5:0], b[0], ~b[0], b[5:0] + 6'd1, b, ~b};
  endfunction

  function automatic logic [31:0] rec_now();
    return {wave, pw, right_en, left_en, vol, freq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid_idx(input logic [4:0] want, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (voice_valid && voice_idx == want) break;
      tick();
    end
    chk("wait_valid_idx", {63'd0, voice_valid && (voice_idx == want)}, 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done) break;
      tick();
    end
    chk("wait_done", {63'd0, done}, 64'd1);
  endtask

  function automatic logic [46:0] all_outs();
    return {ram_rd_en, ram_rd_addr, voice_valid, voice_idx, freq, vol,
            left_en, right_en, pw, wave, busy, done, overrun};
  endfunction

  initial begin
    int nvalid;
    int ndone;
    int first_valid;
    int done_edge;
    logic [31:0] held;
    logic [4:0] seen [0:1];

    checks = 0;
    failures = 0;
    rst = 1'b1;
    strobe = 1'b0;
    voice_ready = 1'b1;
    overrun_clr = 1'b0;
    ram_rd_data = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = word_of(i);

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", {17'd0, all_outs()}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Full scan with ready high, plus a strobe while busy around cycle 20
    nvalid = 0; ndone = 0; first_valid = 0; done_edge = 0;
    strobe = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      tick();
      if (k == 1) strobe = 1'b0;
      if (k == 20) strobe = 1'b1;
      if (k == 21) strobe = 1'b0;
      if (voice_valid) begin
        if (nvalid == 0) begin
          first_valid = k;
          chk("v0_freq", {48'd0, freq}, 64'h1234);
          chk("v0_vol", {58'd0, vol}, 64'h12);
          chk("v0_left", {63'd0, left_en}, 64'd1);
          chk("v0_right", {63'd0, right_en}, 64'd1);
          chk("v0_pw", {58'd0, pw}, 64'h05);
          chk("v0_wave", {62'd0, wave}, 64'd3);
        end
        chk("scan_idx", {59'd0, voice_idx}, 64'(nvalid));
        chk("scan_rec", {32'd0, rec_now()}, {32'd0, word_of(nvalid)});
        nvalid++;
      end
      if (done) begin
        ndone++;
        if (done_edge == 0) done_edge = k;
      end
    end
    chk("first_valid_edge", 64'(first_valid), 64'd3);
    chk("valid_count", 64'(nvalid), 64'd32);
    chk("done_edge", 64'(done_edge), 64'd97);
    chk("done_pulses", 64'(ndone), 64'd1);
    chk("busy_after_scan", {63'd0, busy}, 64'd0);
    chk("overrun_set", {63'd0, overrun}, 64'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("overrun_cleared", {63'd0, overrun}, 64'd0);

    // Back-pressure on voice 5, with strobe and clear colliding while busy
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    wait_valid_idx(5'd5, 100);
    voice_ready = 1'b0;
    held = rec_now();
    chk("v5_rec", {32'd0, held}, {32'd0, word_of(5)});
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin strobe = 1'b1; overrun_clr = 1'b1; end
      tick();
      if (k == 4) begin strobe = 1'b0; overrun_clr = 1'b0; end
      chk("hold_valid", {63'd0, voice_valid}, 64'd1);
      chk("hold_idx", {59'd0, voice_idx}, 64'd5);
      chk("hold_rec", {32'd0, rec_now()}, {32'd0, held});
      chk("hold_no_fetch", {63'd0, ram_rd_en}, 64'd0);
    end
    chk("overrun_set_wins", {63'd0, overrun}, 64'd1);
    voice_ready = 1'b1;
    tick();
    chk("v6_fetch_en", {63'd0, ram_rd_en}, 64'd1);
    chk("v6_fetch_addr", {59'd0, ram_rd_addr}, 64'd6);
    chk("v6_no_valid", {63'd0, voice_valid}, 64'd0);
    wait_done(200);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("overrun_clr2", {63'd0, overrun}, 64'd0);

    // Asynchronous reset during voice 12 OUT aborts the scan
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    wait_valid_idx(5'd12, 100);
    voice_ready = 1'b0;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    chk("pre_reset_overrun", {63'd0, overrun}, 64'd1);
    chk("pre_reset_addr", {59'd0, ram_rd_addr}, 64'd12);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {17'd0, all_outs()}, 64'd0);
    tick();
    rst = 1'b0;
    voice_ready = 1'b1;
    tick();
    chk("post_reset_no_done", {63'd0, done}, 64'd0);
    strobe = 1'b1;
    first_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) strobe = 1'b0;
      if (voice_valid && first_valid == 0) begin
        first_valid = k;
        chk("restart_idx", {59'd0, voice_idx}, 64'd0);
        chk("restart_rec", {32'd0, rec_now()}, {32'd0, word_of(0)});
      end
    end
    chk("restart_edge", 64'(first_valid), 64'd3);
    wait_done(200);
    tick();

`ifdef AUDIO_ATTR_SKIP_MUTED_EN
    // Only voices 3 and 30 have non-zero volume
    for (int i = 0; i < 32; i++) begin
      if (i == 3 || i == 30) mem[i] = word_of(i);
      else mem[i] = word_of(i) & 32'hFFC0_FFFF;
    end
    nvalid = 0; ndone = 0;
    seen[0] = 5'd0; seen[1] = 5'd0;
    strobe = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      tick();
      if (k == 1) strobe = 1'b0;
      if (voice_valid) begin
        if (nvalid < 2) seen[nvalid] = voice_idx;
        nvalid++;
      end
      if (done) ndone++;
    end
    chk("skip_valid_count", 64'(nvalid), 64'd2);
    chk("skip_first_idx", {59'd0, seen[0]}, 64'd3);
    chk("skip_second_idx", {59'd0, seen[1]}, 64'd30);
    chk("skip_done", 64'(ndone), 64'd1);

    // All voices muted
    for (int i = 0; i < 32; i++) mem[i] = word_of(i) & 32'hFFC0_FFFF;
    nvalid = 0; done_edge = 0;
    strobe = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 1) strobe = 1'b0;
      if (voice_valid) nvalid++;
      if (done && done_edge == 0) done_edge = k;
    end
    chk("muted_no_valid", 64'(nvalid), 64'd0);
    chk("muted_done_edge", 64'(done_edge), 64'd65);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
